// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared snake encodings and default grid constants
// Purpose: direction and FSM encodings plus default grid/length constants
//          shared by the move controller, renderer and food logic.
// Ports:   none (package)
package snake_pkg;

  localparam int GRID_W_DEF  = 32;
  localparam int GRID_H_DEF  = 24;
  localparam int MAX_LEN_DEF = 16;

  typedef enum logic [1:0] {
    RIGHT = 2'b00,
    LEFT  = 2'b01,
    UP    = 2'b10,
    DOWN  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  // Opposite directions differ only in bit 0 with this encoding.
  function automatic dir_t reverse_of(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_dir_latch.sv
// rtl/snake_dir_latch.sv - button decode, reverse rejection, direction registers
// Purpose: decodes the level button requests (up > down > left > right),
//          drops a request that would reverse the snake, and holds the
//          pending and committed directions.
// Ports:   clk, reset           - clock, async active-high reset
//          btn_up/down/left/right - level direction requests
//          enable               - allow pending_dir updates (IDLE/RUN)
//          commit               - a move is committed this cycle
//          press                - any button is high
//          pending_dir          - direction used by the next move
//          dir                  - committed direction
module snake_dir_latch
  import snake_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic enable,
  input  logic commit,
  output logic press,
  output dir_t pending_dir,
  output dir_t dir
);

  dir_t req;
  dir_t ref_dir;
  logic accept;

  always_comb begin
    req = RIGHT;
    if (btn_up)
      req = UP;
    else if (btn_down)
      req = DOWN;
    else if (btn_left)
      req = LEFT;
    else
      req = RIGHT;
  end

  assign press = btn_up | btn_down | btn_left | btn_right;

  // On a commit cycle the direction about to become committed is the one a
  // new request must not reverse, otherwise a quick double press could fold
  // the head back into the neck.
  assign ref_dir = commit ? pending_dir : dir;
  assign accept  = enable && press && (req != reverse_of(ref_dir));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_dir <= RIGHT;
      dir         <= RIGHT;
    end else begin
      if (commit)
        dir <= pending_dir;
      if (accept)
        pending_dir <= req;
    end
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// rtl/snake_move_ctrl.sv - snake movement, growth and collision controller
// Purpose: advances the snake one cell per update_clk tick, keeps the segment
//          history, handles growth and detects self/wall collisions.
// Config:  SNAKE_WRAP_EN defined   -> edges wrap around the grid
//          SNAKE_WRAP_EN undefined -> moving off an edge ends the game
// Ports:   clk, reset        - clock, async active-high reset
//          update_clk        - one-cycle move tick
//          btn_up/down/left/right - level direction requests
//          grow              - pulse, lengthen on the next move
//          seg_idx           - segment read index (0 = head)
//          seg_x, seg_y      - combinational read of segment seg_idx
//          head_x, head_y    - current head position
//          dir               - committed direction
//          length            - live segment count
//          moved             - one-cycle pulse after a committed move
//          game_over         - high in OVER
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter  int GRID_W  = GRID_W_DEF,
  parameter  int GRID_H  = GRID_H_DEF,
  parameter  int MAX_LEN = MAX_LEN_DEF,
  parameter  int START_X = 16,
  parameter  int START_Y = 12,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int IW = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          update_clk,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          grow,
  input  logic [IW-1:0] seg_idx,
  output logic [XW-1:0] seg_x,
  output logic [YW-1:0] seg_y,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [1:0]    dir,
  output logic [LW-1:0] length,
  output logic          moved,
  output logic          game_over
);

  state_t        state, state_nx;
  logic [XW-1:0] segs_x [MAX_LEN];
  logic [YW-1:0] segs_y [MAX_LEN];
  logic [LW-1:0] len_q;
  logic          grow_pend;
  logic          moved_q;

  dir_t          pending_dir;
  dir_t          dir_q;
  logic          press;

  logic          tick_run;
  logic          grow_eff;
  logic [XW-1:0] nx_x;
  logic [YW-1:0] nx_y;
  logic          wall;
  logic          self_hit;
  logic          hit;
  logic          do_move;
  logic [LW-1:0] cmp_cnt;

  snake_dir_latch u_dir_latch (
    .clk         (clk),
    .reset       (reset),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .enable      (state != ST_OVER),
    .commit      (do_move),
    .press       (press),
    .pending_dir (pending_dir),
    .dir         (dir_q)
  );

  assign tick_run = (state == ST_RUN) && update_clk;
  // A grow arriving with the tick counts for that tick.
  assign grow_eff = (grow_pend || grow) && (len_q != LW'(MAX_LEN));

  // Next head position from the pending direction.
  always_comb begin
    nx_x = segs_x[0];
    nx_y = segs_y[0];
    wall = 1'b0;
    case (pending_dir)
      RIGHT: begin
        if (segs_x[0] == XW'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
          nx_x = '0;
`else
          wall = 1'b1;
`endif
        end else begin
          nx_x = segs_x[0] + XW'(1);
        end
      end
      LEFT: begin
        if (segs_x[0] == '0) begin
`ifdef SNAKE_WRAP_EN
          nx_x = XW'(GRID_W - 1);
`else
          wall = 1'b1;
`endif
        end else begin
          nx_x = segs_x[0] - XW'(1);
        end
      end
      UP: begin
        if (segs_y[0] == '0) begin
`ifdef SNAKE_WRAP_EN
          nx_y = YW'(GRID_H - 1);
`else
          wall = 1'b1;
`endif
        end else begin
          nx_y = segs_y[0] - YW'(1);
        end
      end
      default: begin
        if (segs_y[0] == YW'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
          nx_y = '0;
`else
          wall = 1'b1;
`endif
        end else begin
          nx_y = segs_y[0] + YW'(1);
        end
      end
    endcase
  end

  // The tail cell vacates on a plain move, so it is only a hazard when the
  // snake grows on this tick.
  always_comb begin
    self_hit = 1'b0;
    cmp_cnt  = grow_eff ? len_q : len_q - LW'(1);
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < cmp_cnt) && (segs_x[i] == nx_x) && (segs_y[i] == nx_y))
        self_hit = 1'b1;
    end
  end

  assign hit     = wall || self_hit;
  assign do_move = tick_run && !hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (press) state_nx = ST_RUN;
      ST_RUN:  if (tick_run && hit) state_nx = ST_OVER;
      ST_OVER: state_nx = ST_OVER;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        segs_x[i] <= (i < 3) ? XW'(START_X - i) : '0;
        segs_y[i] <= (i < 3) ? YW'(START_Y) : '0;
      end
      len_q     <= LW'(3);
      grow_pend <= 1'b0;
      moved_q   <= 1'b0;
    end else begin
      moved_q <= do_move;
      if (do_move) begin
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          segs_x[i] <= segs_x[i-1];
          segs_y[i] <= segs_y[i-1];
        end
        segs_x[0] <= nx_x;
        segs_y[0] <= nx_y;
        if (grow_eff)
          len_q <= len_q + LW'(1);
        grow_pend <= 1'b0;
      end else if (grow && (state != ST_OVER)) begin
        grow_pend <= 1'b1;
      end
    end
  end

  assign seg_x     = (int'(seg_idx) < MAX_LEN) ? segs_x[seg_idx] : '0;
  assign seg_y     = (int'(seg_idx) < MAX_LEN) ? segs_y[seg_idx] : '0;
  assign head_x    = segs_x[0];
  assign head_y    = segs_y[0];
  assign dir       = dir_q;
  assign length    = len_q;
  assign moved     = moved_q;
  assign game_over = (state == ST_OVER);

endmodule
